// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed seven-segment controller: active-low
// segment codes (bit0=a .. bit6=g, bit7=dp), the PWM phase width and the guard phase.
package sseg_pkg;

  localparam int unsigned PHASE_W     = 4;
  localparam logic [3:0]  GUARD_PHASE = 4'd15;

  localparam logic [7:0] SEG_OFF     = 8'hFF;
  localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  function automatic logic [7:0] hex_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble + decimal point to active-low cathode code.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathode
);

  always_comb begin
    cathode = hex_seg(nibble);
    if (dp) cathode[7] = 1'b0;
  end

endmodule

// File: rtl/sseg_mux_controller.sv
// N-digit multiplexed seven-segment controller with PWM brightness and a
// double-buffered load. Define SSEG_LZ_BLANK_EN to blank leading zero digits.
module sseg_mux_controller
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 4,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REFRESH_HZ = 10_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic                    pending,
  output logic                    frame_done,
  output logic [N_DIGITS-1:0]     sseg_anode,
  output logic [7:0]              sseg_cathode
);

  localparam int unsigned PRE_DIV = CLK_HZ / (16 * REFRESH_HZ);
  localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PRE_W-1:0]      pre_cnt;
  logic [PHASE_W-1:0]    phase;
  logic [IDX_W-1:0]      idx;
  logic                  tick, phase_wrap, frame_wrap;

  logic [4*N_DIGITS-1:0] act_digits, stg_digits;
  logic [N_DIGITS-1:0]   act_dp, stg_dp, act_blank, stg_blank;

  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic [7:0]            dec_code;
  logic [N_DIGITS-1:0]   lz;
  logic                  lit;
  logic [N_DIGITS-1:0]   anode_next;
  logic [7:0]            cathode_next;

  assign tick       = (pre_cnt == PRE_W'(PRE_DIV - 1));
  assign phase_wrap = tick && (phase == GUARD_PHASE);
  assign frame_wrap = phase_wrap && (idx == IDX_W'(N_DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      phase      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
      frame_done <= frame_wrap;
      if (tick) phase <= phase + 1'b1;
      if (phase_wrap) idx <= frame_wrap ? '0 : idx + 1'b1;
    end
  end

  // Staging and active update independently, so a load coinciding with the
  // frame wrap promotes the old staging contents and keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_digits <= '0;
      stg_dp     <= '0;
      stg_blank  <= '1;
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp;
        stg_blank  <= blank;
      end
      if (frame_wrap && pending) begin
        act_digits <= stg_digits;
        act_dp     <= stg_dp;
        act_blank  <= stg_blank;
      end
      if (load)            pending <= 1'b1;
      else if (frame_wrap) pending <= 1'b0;
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  always_comb begin
    logic seen;
    seen = 1'b0;
    lz   = '0;
    for (int unsigned k = 0; k < N_DIGITS - 1; k++) begin
      if (act_digits[(N_DIGITS-1-k)*4 +: 4] != 4'h0) seen = 1'b1;
      lz[N_DIGITS-1-k] = !seen;
    end
  end
`else
  assign lz = '0;
`endif

  assign cur_nibble = act_digits[idx*4 +: 4];
  assign cur_dp     = act_dp[idx];

  sseg_hex_decoder u_dec (
    .nibble  (cur_nibble),
    .dp      (cur_dp),
    .cathode (dec_code)
  );

  always_comb begin
    lit = (phase < brightness) && (phase != GUARD_PHASE) &&
          !act_blank[idx] && !(lz[idx] && !cur_dp);
    anode_next   = '1;
    cathode_next = SEG_OFF;
    if (lit) begin
      anode_next[idx] = 1'b0;
      cathode_next    = lz[idx] ? SEG_DP_ONLY : dec_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg_anode   <= '1;
      sseg_cathode <= SEG_OFF;
    end else begin
      sseg_anode   <= anode_next;
      sseg_cathode <= cathode_next;
    end
  end

endmodule

// File: tb/tb_sseg_mux_controller.sv
// Directed bench for sseg_mux_controller with a per-cycle expectation queue;
// PRE_DIV=1 so the scan advances one phase per clock.
module tb_sseg_mux_controller;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } frame_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] ca;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp, blank, brightness;
  logic        load;
  logic        pending, frame_done;
  logic [3:0]  sseg_anode;
  logic [7:0]  sseg_cathode;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  sseg_mux_controller #(
    .N_DIGITS   (4),
    .CLK_HZ     (1600),
    .REFRESH_HZ (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digits       (digits),
    .dp           (dp),
    .blank        (blank),
    .load         (load),
    .brightness   (brightness),
    .pending      (pending),
    .frame_done   (frame_done),
    .sseg_anode   (sseg_anode),
    .sseg_cathode (sseg_cathode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input frame_t f, input logic [3:0] br,
                                 input int idx, input int ph, input logic fd);
    exp_t e;
    logic [3:0] lzm;
    logic [7:0] seg;
    logic       on;
    lzm = '0;
`ifdef SSEG_LZ_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (f.d[i*4 +: 4] != 4'h0) break;
      lzm[i] = 1'b1;
    end
`endif
    seg = seg_tbl[f.d[idx*4 +: 4]];
    if (f.dp[idx]) seg[7] = 1'b0;
    on = (ph < int'(br)) && (ph != 15) && !f.bl[idx] && !(lzm[idx] && !f.dp[idx]);
    e.an = 4'hF;
    e.ca = 8'hFF;
    e.fd = fd;
    if (on) begin
      e.an[idx] = 1'b0;
      e.ca      = lzm[idx] ? 8'h7F : seg;
    end
    return e;
  endfunction

  task automatic drive(input frame_t f, input logic ld);
    digits = f.d;
    dp     = f.dp;
    blank  = f.bl;
    load   = ld;
  endtask

  // Starts just after a frame_done sample and ends on the next one.
  task automatic run_frame(input string tag, input frame_t shown, input logic [3:0] br,
                           input int la1, input frame_t a1, input int la2, input frame_t a2);
    exp_t e;
    for (int j = 1; j <= 64; j++)
      sb.push_back(model(shown, br, (j - 1) / 16, (j - 1) % 16, j == 64));
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, "_anode"},   32'(sseg_anode),   32'(e.an));
      chk({tag, "_cathode"}, 32'(sseg_cathode), 32'(e.ca));
      chk({tag, "_fdone"},   32'(frame_done),   32'(e.fd));
      if (j == la1)      drive(a1, 1'b1);
      else if (j == la2) drive(a2, 1'b1);
      else               load = 1'b0;
    end
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("frame_done_wait", 32'(frame_done), 32'd1);
  endtask

  frame_t f_rst, f_3210, f_a, f_b, f_c, f_d, f_lz, f_none;

  initial begin
    f_rst  = '{d: 16'h0000, dp: 4'b0000, bl: 4'b1111};
    f_3210 = '{d: 16'h3210, dp: 4'b0000, bl: 4'b0000};
    f_a    = '{d: 16'hABCD, dp: 4'b0101, bl: 4'b0000};
    f_b    = '{d: 16'h9E76, dp: 4'b1010, bl: 4'b0100};
    f_c    = '{d: 16'hF845, dp: 4'b0001, bl: 4'b0000};
    f_d    = '{d: 16'h1B2C, dp: 4'b0000, bl: 4'b1000};
    f_lz   = '{d: 16'h0050, dp: 4'b1000, bl: 4'b0000};
    f_none = f_rst;

    rst = 1'b1;
    brightness = 4'd15;
    drive(f_none, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_anode",   32'(sseg_anode),   32'hF);
    chk("rst_cathode", 32'(sseg_cathode), 32'hFF);
    chk("rst_pending", 32'(pending),      32'd0);
    chk("rst_fdone",   32'(frame_done),   32'd0);
    rst = 1'b0;

    // Reset-state buffers are fully blanked.
    wait_fd();
    run_frame("blank", f_rst, 4'd15, 0, f_none, 0, f_none);

    drive(f_3210, 1'b1);
    @(negedge clk);
    load = 1'b0;
    chk("pend_set", 32'(pending), 32'd1);
    wait_fd();
    chk("pend_clr", 32'(pending), 32'd0);

    // Basic scan; loads A then B mid-frame, only B must appear next.
    run_frame("scan", f_3210, 4'd15, 10, f_a, 40, f_b);
    chk("pend_after_ab", 32'(pending), 32'd0);

    // Brightness 4, with D staged mid-frame and C loaded on the wrap cycle.
    brightness = 4'd4;
    run_frame("tear_b", f_b, 4'd4, 20, f_d, 63, f_c);
    chk("pend_wrap_load", 32'(pending), 32'd1);

    brightness = 4'd0;
    run_frame("bright0", f_d, 4'd0, 0, f_none, 0, f_none);
    chk("pend_c_promoted", 32'(pending), 32'd0);

    brightness = 4'd15;
    run_frame("show_c", f_c, 4'd15, 5, f_lz, 0, f_none);
    run_frame("lz", f_lz, 4'd15, 0, f_none, 0, f_none);

    // Asynchronous reset mid-scan with a pending load.
    repeat (7) @(negedge clk);
    drive(f_a, 1'b1);
    @(negedge clk);
    load = 1'b0;
    chk("pend_before_rst", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_anode",   32'(sseg_anode),   32'hF);
    chk("midrst_cathode", 32'(sseg_cathode), 32'hFF);
    chk("midrst_pending", 32'(pending),      32'd0);
    chk("midrst_fdone",   32'(frame_done),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
